// File: rtl/spis_pkg.sv
// Shared types and defaults for the SPI slave block.
package spis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spis_state_e;

    localparam int         SPIS_DATA_W    = 8;
    localparam logic [7:0] SPIS_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spis_sync.sv
// Multi-flop synchroniser for an asynchronous pad input with rise/fall detection
// on the synchronised level.
module spis_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   level_s;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level_s = sync_r[SYNC_STAGES-1];
    assign rise    = level_s & ~prev_r;
    assign fall    = ~level_s & prev_r;

endmodule

// File: rtl/spis_top.sv
// SPI mode-0 slave: pad inputs synchronised into module_clk, full-duplex frames,
// 1-deep transmit buffer and a pulsed receive interface.
module spis_top
    import spis_pkg::*;
#(
    parameter int                DATA_W      = SPIS_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(SPIS_IDLE_FILL)
) (
    input  logic              module_clk,
    input  logic              module_rst,
    input  logic              spis_sck,
    input  logic              spis_cs_n,
    input  logic              spis_mosi,
    output logic              spis_miso_o,
    output logic              spis_miso_oen,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    spis_state_e            state_r, state_s;
    logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_s;
    logic [DATA_W-2:0]      shift_rx_r, shift_rx_s;
    logic [DATA_W-2:0]      shift_tx_r, shift_tx_s;
    logic [DATA_W-1:0]      tx_buf_r, tx_buf_s;
    logic [DATA_W-1:0]      rx_data_r, rx_data_s;
    logic                   tx_full_r, tx_full_s;
    logic                   reload_pending_r, reload_pending_s;
    logic                   miso_r, miso_s;
    logic                   miso_oen_r, miso_oen_s;
    logic                   rx_valid_r, rx_valid_s;
    logic                   underrun_r, underrun_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   mosi_s;
    logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
    logic                   load_s, tx_accept_s;
    logic [DATA_W-1:0]      load_byte_s;

    spis_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(module_clk), .rst(module_rst), .din(spis_sck),
        .rise(sck_rise_s), .fall(sck_fall_s)
    );

    spis_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(module_clk), .rst(module_rst), .din(spis_cs_n),
        .rise(cs_rise_s), .fall(cs_fall_s)
    );

    // MOSI synchroniser, same depth as SCK so data and clock stay aligned
    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spis_mosi};
        end
    end

    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign tx_accept_s = tx_valid & ~tx_full_r;
    assign load_byte_s = tx_full_r ? tx_buf_r : IDLE_FILL;

    // Next-state and datapath logic; CS deassertion has priority over SCK edges
    always_comb begin
        state_s          = state_r;
        bit_cnt_s        = bit_cnt_r;
        shift_rx_s       = shift_rx_r;
        shift_tx_s       = shift_tx_r;
        tx_buf_s         = tx_buf_r;
        tx_full_s        = tx_full_r;
        reload_pending_s = reload_pending_r;
        miso_s           = miso_r;
        miso_oen_s       = miso_oen_r;
        rx_data_s        = rx_data_r;
        rx_valid_s       = 1'b0;
        underrun_s       = 1'b0;
        load_s           = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_s    = ACTIVE;
                    load_s     = 1'b1;
                    bit_cnt_s  = {CNT_W{1'b0}};
                    miso_oen_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_s          = IDLE;
                    bit_cnt_s        = {CNT_W{1'b0}};
                    reload_pending_s = 1'b0;
                    miso_oen_s       = 1'b1;
                    miso_s           = 1'b1;
                end else if (sck_rise_s) begin
                    shift_rx_s = {shift_rx_r[DATA_W-3:0], mosi_s};
                    if (bit_cnt_r == CNT_LAST) begin
                        rx_data_s        = {shift_rx_r, mosi_s};
                        rx_valid_s       = 1'b1;
                        bit_cnt_s        = {CNT_W{1'b0}};
                        reload_pending_s = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end
                end else if (sck_fall_s) begin
                    if (reload_pending_r) begin
                        load_s           = 1'b1;
                        reload_pending_s = 1'b0;
                    end else begin
                        miso_s     = shift_tx_r[DATA_W-2];
                        shift_tx_s = {shift_tx_r[DATA_W-3:0], 1'b0};
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A same-cycle tx handshake never bypasses into the shifter
        if (load_s) begin
            shift_tx_s = load_byte_s[DATA_W-2:0];
            miso_s     = load_byte_s[DATA_W-1];
            if (tx_full_r) begin
                tx_full_s = 1'b0;
            end else begin
                underrun_s = 1'b1;
            end
        end else begin
            underrun_s = 1'b0;
        end
        if (tx_accept_s) begin
            tx_buf_s  = tx_data;
            tx_full_s = 1'b1;
        end else begin
            tx_buf_s = tx_buf_r;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst) begin
            state_r          <= IDLE;
            bit_cnt_r        <= {CNT_W{1'b0}};
            shift_rx_r       <= {(DATA_W-1){1'b0}};
            shift_tx_r       <= {(DATA_W-1){1'b0}};
            tx_buf_r         <= {DATA_W{1'b0}};
            rx_data_r        <= {DATA_W{1'b0}};
            tx_full_r        <= 1'b0;
            reload_pending_r <= 1'b0;
            miso_r           <= 1'b1;
            miso_oen_r       <= 1'b1;
            rx_valid_r       <= 1'b0;
            underrun_r       <= 1'b0;
        end else begin
            state_r          <= state_s;
            bit_cnt_r        <= bit_cnt_s;
            shift_rx_r       <= shift_rx_s;
            shift_tx_r       <= shift_tx_s;
            tx_buf_r         <= tx_buf_s;
            rx_data_r        <= rx_data_s;
            tx_full_r        <= tx_full_s;
            reload_pending_r <= reload_pending_s;
            miso_r           <= miso_s;
            miso_oen_r       <= miso_oen_s;
            rx_valid_r       <= rx_valid_s;
            underrun_r       <= underrun_s;
        end
    end

    assign spis_miso_o   = miso_r;
    assign spis_miso_oen = miso_oen_r;
    assign tx_ready      = ~tx_full_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign tx_underrun   = underrun_r;
    assign busy          = (state_r == ACTIVE);

endmodule

// File: tb/tb_spis_top.sv
// Directed bench for spis_top: table of single frames plus hand-written
// back-to-back, abort, same-cycle underrun and mid-frame reset sequences.
module tb_spis_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, cs_n, mosi;
    logic       miso_o, miso_oen;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    int   rx_cnt   = 0;
    int   urun_cnt = 0;
    int   rdy_rise = 0;
    logic rdy_q    = 1'b1;

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_urun;
    } vec_t;

    vec_t vecs[4];

    spis_top dut (
        .module_clk(clk), .module_rst(rst),
        .spis_sck(sck), .spis_cs_n(cs_n), .spis_mosi(mosi),
        .spis_miso_o(miso_o), .spis_miso_oen(miso_oen),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the inactive clock edge
    always @(negedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_underrun) urun_cnt <= urun_cnt + 1;
        if (tx_ready && !rdy_q) rdy_rise <= rdy_rise + 1;
        rdy_q <= tx_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("push_tx_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // nbits bits MSB first at clk/8; when last, CS rises together with the final SCK fall
    task automatic xfer_bits(input logic [7:0] b, input int nbits, input logic last,
                             output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            m[i] = miso_o;
            sck  = 1'b0;
            if (last && i == 8 - nbits) cs_n = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] m0, m1, m2, r0, r1;
        int         rx0, ur0, rr0;

        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso",     {31'd0, miso_o},      32'd1);
        check("rst_oen",      {31'd0, miso_oen},    32'd1);
        check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check("rst_rx_data",  {24'd0, rx_data},     32'h0);
        check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_busy",     {31'd0, busy},        32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].preload) begin
                push_tx(vecs[v].tx);
                check("tx_ready_fall", {31'd0, tx_ready}, 32'd0);
            end
            rx0 = rx_cnt; ur0 = urun_cnt;
            cs_start();
            check("busy_active", {31'd0, busy},     32'd1);
            check("oen_active",  {31'd0, miso_oen}, 32'd0);
            xfer_bits(vecs[v].mosi_b, 8, 1'b1, m0);
            repeat (8) @(negedge clk);
            check("vec_miso",     {24'd0, m0},        {24'd0, vecs[v].exp_miso});
            check("vec_rx_data",  {24'd0, rx_data},   {24'd0, vecs[v].exp_rx});
            check("vec_rx_count", rx_cnt - rx0,       32'd1);
            check("vec_underrun", urun_cnt - ur0,     vecs[v].exp_urun);
            check("vec_oen_idle", {31'd0, miso_oen},  32'd1);
            check("vec_busy_off", {31'd0, busy},      32'd0);
        end

        // Three bytes back-to-back in one CS, tx bytes supplied as tx_ready rises
        push_tx(8'h01);
        rx0 = rx_cnt; ur0 = urun_cnt; rr0 = rdy_rise;
        cs_start();
        fork
            begin
                xfer_bits(8'hC1, 8, 1'b0, m0); r0 = rx_data;
                xfer_bits(8'hC2, 8, 1'b0, m1); r1 = rx_data;
                xfer_bits(8'hC3, 8, 1'b1, m2);
            end
            begin
                push_tx(8'h02);
                push_tx(8'h03);
            end
        join
        repeat (8) @(negedge clk);
        check("b2b_miso0",    {24'd0, m0},      32'h01);
        check("b2b_miso1",    {24'd0, m1},      32'h02);
        check("b2b_miso2",    {24'd0, m2},      32'h03);
        check("b2b_rx0",      {24'd0, r0},      32'hC1);
        check("b2b_rx1",      {24'd0, r1},      32'hC2);
        check("b2b_rx2",      {24'd0, rx_data}, 32'hC3);
        check("b2b_rx_count", rx_cnt - rx0,     32'd3);
        check("b2b_rdy_rise", rdy_rise - rr0,   32'd3);
        check("b2b_underrun", urun_cnt - ur0,   32'd0);

        // Abort after five SCK cycles, then a full frame
        push_tx(8'h66);
        rx0 = rx_cnt;
        cs_start();
        xfer_bits(8'hF0, 5, 1'b1, m0);
        repeat (8) @(negedge clk);
        check("abort_miso_bits", {24'd0, m0 & 8'hF8}, 32'h60);
        check("abort_no_rx",     rx_cnt - rx0,        32'd0);
        check("abort_oen",       {31'd0, miso_oen},   32'd1);
        check("abort_miso_hi",   {31'd0, miso_o},     32'd1);
        check("abort_rx_held",   {24'd0, rx_data},    32'hC3);
        push_tx(8'h5A);
        rx0 = rx_cnt;
        cs_start();
        xfer_bits(8'h96, 8, 1'b1, m0);
        repeat (8) @(negedge clk);
        check("post_abort_miso", {24'd0, m0},      32'h5A);
        check("post_abort_rx",   {24'd0, rx_data}, 32'h96);
        check("post_abort_cnt",  rx_cnt - rx0,     32'd1);

        // tx_valid in the very cycle of the CS-fall load with an empty buffer
        ur0 = urun_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("same_cyc_buffered", {31'd0, tx_ready}, 32'd0);
        repeat (5) @(negedge clk);
        xfer_bits(8'h11, 8, 1'b1, m0);
        repeat (8) @(negedge clk);
        check("same_cyc_fill",     {24'd0, m0},    32'hFF);
        check("same_cyc_underrun", urun_cnt - ur0, 32'd1);
        ur0 = urun_cnt;
        cs_start();
        xfer_bits(8'h22, 8, 1'b1, m0);
        repeat (8) @(negedge clk);
        check("next_frame_byte",     {24'd0, m0},      32'hC3);
        check("next_frame_underrun", urun_cnt - ur0,   32'd0);
        check("next_frame_rx",       {24'd0, rx_data}, 32'h22);

        // Reset in the middle of a frame
        push_tx(8'h44);
        cs_start();
        xfer_bits(8'hAA, 3, 1'b0, m0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_miso",     {31'd0, miso_o},      32'd1);
        check("mid_rst_oen",      {31'd0, miso_oen},    32'd1);
        check("mid_rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check("mid_rst_rx_data",  {24'd0, rx_data},     32'h0);
        check("mid_rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("mid_rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("mid_rst_busy",     {31'd0, busy},        32'd0);
        cs_n = 1'b1; sck = 1'b0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        push_tx(8'h3C);
        rx0 = rx_cnt; ur0 = urun_cnt;
        cs_start();
        xfer_bits(8'hA5, 8, 1'b1, m0);
        repeat (8) @(negedge clk);
        check("post_rst_miso",     {24'd0, m0},      32'h3C);
        check("post_rst_rx",       {24'd0, rx_data}, 32'hA5);
        check("post_rst_rx_count", rx_cnt - rx0,     32'd1);
        check("post_rst_underrun", urun_cnt - ur0,   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
